// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: round-robin arbiter that time-multiplexes one overlapping
// Mealy "1011" detector among NREQ requesters. The granted word is shifted
// MSB-first through the detector; match count and positions are reported.
module seq_scan_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW   = $clog2(WIDTH + 1),
    localparam int BW   = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data_in,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    done,
    output logic [IDW-1:0]          done_id,
    output logic [CW-1:0]           match_cnt,
    output logic [WIDTH-1:0]        match_vec
);

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
    typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

    state_t                      state_q, state_d;
    det_t                        det_q, det_d;
    logic [IDW-1:0]              ptr_q, ptr_d;
    logic [IDW-1:0]              cur_q, cur_d;
    logic [IDW-1:0]              did_q, did_d;
    logic [WIDTH-1:0]            sh_q, sh_d;
    logic [BW-1:0]               bit_q, bit_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [WIDTH-1:0]            vec_q, vec_d;
    logic [NREQ-1:0]             gnt_q, gnt_d;

    logic [NREQ-1:0][WIDTH-1:0]  words;
    logic                        win_vld;
    logic [IDW-1:0]              win_id;
    logic [IDW-1:0]              idx;
    logic                        x, z;
    logic [BW-1:0]               pos;

    assign words = data_in;

    // Round-robin pick: first asserted request at or after ptr, with wraparound.
    // Scanning offsets from high to low lets the smallest offset win.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = '0;
        for (int o = NREQ - 1; o >= 0; o--) begin
            idx = IDW'((int'(ptr_q) + o) % NREQ);
            if (req[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    // Next-state logic for the controller FSM, detector and result registers.
    always_comb begin
        state_d = state_q;
        det_d   = det_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        did_d   = did_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        gnt_d   = '0;
        x       = sh_q[WIDTH-1];
        z       = (det_q == S3) && x;
        pos     = BW'(WIDTH - 1) - bit_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    sh_d    = words[win_id];
                    gnt_d   = NREQ'(1) << win_id;
                    cur_d   = win_id;
                    ptr_d   = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
                    det_d   = S0;
                    bit_d   = '0;
                    cnt_d   = '0;
                    vec_d   = '0;
                    did_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_d = {sh_q[WIDTH-2:0], 1'b0};
                case (det_q)
                    S0: det_d = x ? S1 : S0;
                    S1: det_d = x ? S1 : S2;
                    S2: det_d = x ? S3 : S0;
                    S3: det_d = x ? S1 : S2;
                    default: det_d = S0;
                endcase
                if (z) begin
                    cnt_d      = cnt_q + 1'b1;
                    vec_d[pos] = 1'b1;
                end
                bit_d = bit_q + 1'b1;
                if (bit_q == BW'(WIDTH - 1)) begin
                    did_d   = cur_q;
                    state_d = REPORT;
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any job in flight and rewinds the pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            det_q   <= S0;
            ptr_q   <= '0;
            cur_q   <= '0;
            did_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            did_q   <= did_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == REPORT);
    assign done_id   = did_q;
    assign match_cnt = cnt_q;
    assign match_vec = vec_q;

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Bench for seq_scan_arbiter: directed scenarios plus randomized jobs checked
// against a substring-search reference and a round-robin pointer model.
module tb_seq_scan_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;
    localparam int CW    = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data_in;
    logic [NREQ-1:0]       gnt;
    logic                  busy, done;
    logic [IDW-1:0]        done_id;
    logic [CW-1:0]         match_cnt;
    logic [WIDTH-1:0]      match_vec;

    int vectors = 0;
    int miscompares = 0;
    int ptr_m = 0;
    int cyc = 0;
    int last_gnt_cyc = -1;

    seq_scan_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
        .match_cnt(match_cnt), .match_vec(match_vec)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter for grant spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: count every (overlapping) occurrence of 1011 in the MSB-first
    // bit stream; mark the position of the last bit of each occurrence.
    function automatic void ref_scan(input logic [WIDTH-1:0] w, output int cnt,
                                     output logic [WIDTH-1:0] vec);
        logic [3:0] win;
        cnt = 0;
        vec = '0;
        for (int k = 3; k < WIDTH; k++) begin
            win = w[WIDTH+2-k -: 4];
            if (win == 4'b1011) begin
                cnt++;
                vec[WIDTH-1-k] = 1'b1;
            end
        end
    endfunction

    function automatic int arb(input logic [NREQ-1:0] rq, input int p);
        for (int o = 0; o < NREQ; o++)
            if (rq[(p + o) % NREQ]) return (p + o) % NREQ;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete job from an IDLE cycle through the following IDLE cycle.
    task automatic do_job(input logic [NREQ-1:0] rq, input bit keep, input bit wiggle);
        int w, ecnt;
        logic [WIDTH-1:0] word, evec;
        req  = rq;
        w    = arb(rq, ptr_m);
        word = data_in[w*WIDTH +: WIDTH];
        ref_scan(word, ecnt, evec);
        tick;
        chk("gnt", gnt, 32'(1) << w);
        chk("busy_shift", busy, 1);
        chk("done_at_gnt", done, 0);
        chk("cnt_cleared", match_cnt, 0);
        if (keep && last_gnt_cyc >= 0) chk("gnt_period", cyc - last_gnt_cyc, WIDTH + 2);
        last_gnt_cyc = cyc;
        ptr_m = (w + 1) % NREQ;
        if (!keep) req[w] = 1'b0;
        data_in[w*WIDTH +: WIDTH] = ~word;
        for (int c = 2; c <= WIDTH; c++) begin
            if (wiggle) req = NREQ'($urandom);
            tick;
            chk("gnt_in_shift", gnt, 0);
            chk("done_in_shift", done, 0);
        end
        tick;
        chk("done", done, 1);
        chk("done_id", done_id, w);
        chk("match_cnt", match_cnt, ecnt);
        chk("match_vec", match_vec, evec);
        chk("busy_report", busy, 1);
        chk("gnt_report", gnt, 0);
        if (wiggle) req = '0;
        tick;
        chk("busy_idle", busy, 0);
        chk("done_idle", done, 0);
        chk("cnt_hold", match_cnt, ecnt);
        chk("vec_hold", match_vec, evec);
        chk("id_hold", done_id, w);
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        data_in = '0;
        tick;
        tick;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_id", done_id, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_vec", match_vec, 0);
        reset = 1'b0;
        tick;

        data_in[0*WIDTH +: WIDTH] = 8'hB6;
        do_job(4'b0001, 0, 0);
        data_in[2*WIDTH +: WIDTH] = 8'hBB;
        do_job(4'b0100, 0, 0);
        data_in[2*WIDTH +: WIDTH] = 8'h2D;
        do_job(4'b0100, 0, 0);
        data_in[2*WIDTH +: WIDTH] = 8'hFF;
        do_job(4'b0100, 0, 0);

        // Pointer fairness.
        do_job(4'b1000, 0, 0);
        do_job(4'b1001, 0, 0);
        do_job(4'b0010, 0, 0);
        do_job(4'b1001, 0, 0);

        // Continuous requests from everyone: 0,1,2,3,0 at a fixed period.
        data_in = {8'h5B, 8'h2D, 8'hBB, 8'hB6};
        last_gnt_cyc = -1;
        for (int j = 0; j < 5; j++) do_job(4'b1111, 1, 0);
        req = '0;
        tick;

        // Reset in SHIFT cycle 4 aborts the job and rewinds the pointer.
        data_in[0*WIDTH +: WIDTH] = 8'hB6;
        req = 4'b0001;
        tick;
        chk("abort_gnt", gnt, 1);
        req = '0;
        tick; tick; tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        ptr_m = 0;
        chk("abort_busy", busy, 0);
        chk("abort_gnt_clr", gnt, 0);
        chk("abort_done", done, 0);
        chk("abort_cnt", match_cnt, 0);
        chk("abort_vec", match_vec, 0);
        for (int c = 0; c < WIDTH + 2; c++) begin
            tick;
            chk("abort_no_done", done, 0);
        end
        do_job(4'b0011, 0, 0);
        data_in[1*WIDTH +: WIDTH] = 8'hB6;
        do_job(4'b0010, 0, 0);

        // Randomized jobs with random data and req noise during SHIFT.
        for (int j = 0; j < 30; j++) begin
            logic [NREQ-1:0] rq;
            for (int i = 0; i < NREQ; i++) data_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            do_job(rq, 0, bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
